// File: rtl/rr_packet_aggregator.sv
// rr_packet_aggregator: round-robin merge of NUM_CH header+payload packet streams into one registered output.
// Define RR_AGG_CH_TAG_EN to stamp the grant index into the top CH_W bits of each output header beat.
module rr_packet_aggregator #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_CH = 4,
    parameter int LEN_WIDTH = 8,
    parameter int MAX_LEN = 64,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [CH_W-1:0]              out_ch,
    output logic                         len_err
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
    state_t state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, out_ch_q, out_ch_d, pick, idx, grant_nxt;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d, hdr_len;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, beat, out_beat;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, len_err_q, len_err_d;
    logic found, out_free, xfer, pkt_end;

    assign out_free  = !out_valid_q || out_ready;
    assign xfer      = (state_q != IDLE) && out_free && in_valid[grant_q];
    assign beat      = in_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign hdr_len   = beat[LEN_WIDTH-1:0];
    assign grant_nxt = (grant_q == CH_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
    assign pkt_end   = (state_q == HEADER) ? (hdr_len == '0) : (remaining_q == LEN_WIDTH'(1));

`ifdef RR_AGG_CH_TAG_EN
    always_comb begin
        out_beat = beat;
        if (state_q == HEADER) out_beat[DATA_WIDTH-1 -: CH_W] = grant_q;
    end
`else
    assign out_beat = beat;
`endif

    always_comb begin
        in_ready = '0;
        in_ready[grant_q] = (state_q != IDLE) && out_free;
    end

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick = rr_ptr_q;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_ptr_d = rr_ptr_q;
        remaining_d = remaining_q;
        len_err_d = len_err_q;
        out_data_d = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d = out_last_q;
        out_ch_d = out_ch_q;
        if (state_q == IDLE && found) begin
            grant_d = pick;
            state_d = HEADER;
        end
        if (xfer) begin
            out_data_d = out_beat;
            out_valid_d = 1'b1;
            out_last_d = pkt_end;
            out_ch_d = grant_q;
            remaining_d = (state_q == HEADER) ? ((hdr_len > MAX_L) ? MAX_L : hdr_len) : remaining_q - 1'b1;
            len_err_d = len_err_q || (state_q == HEADER && hdr_len > MAX_L);
            state_d = pkt_end ? IDLE : PAYLOAD;
            rr_ptr_d = pkt_end ? grant_nxt : rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_ptr_q <= '0;
            remaining_q <= '0;
            len_err_q <= 1'b0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            out_ch_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            remaining_q <= remaining_d;
            len_err_q <= len_err_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q <= out_last_d;
            out_ch_q <= out_ch_d;
        end
    end

    assign out_data = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last = out_last_q;
    assign out_ch = out_ch_q;
    assign len_err = len_err_q;
endmodule

// File: doc/rr_packet_aggregator.md
Name: rr_packet_aggregator

Overview:
- Parametrised successor to the two-engine aggregator. Merges NUM_CH packet streams into one output stream, with round-robin arbitration at packet granularity.
- Packet format: one header beat, then the payload beats. The payload beat count sits in the header's low LEN_WIDTH bits.
- A granted channel keeps the output until its last beat. No interleaving between channels.
- Sits between the engine array and the downstream packer. Uses per-channel valid/ready and a registered output stage.

Parameters:
- DATA_WIDTH, 256, beat width in bits (true width, not width-1).
- NUM_CH, 4, number of input channels, 2..16.
- LEN_WIDTH, 8, header length field width; field is header[LEN_WIDTH-1:0].
- MAX_LEN, 64, maximum payload beats per packet; larger lengths are clamped.
- CH_W, $clog2(NUM_CH), channel index width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_data  in  NUM_CH*DATA_WIDTH  channel c occupies [c*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_CH  per-channel beat valid.
- in_ready  out  NUM_CH  per-channel beat accept.
- out_data  out  DATA_WIDTH  output beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  marks the final beat of a packet.
- out_ch  out  CH_W  source channel of the current beat.
- len_err  out  1  sticky; set when a header length exceeded MAX_LEN.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State=IDLE; out_valid, out_last, len_err, in_ready = 0; out_data, out_ch = 0.
  - rr_ptr=0; remaining=0.
  - Reset mid-packet abandons the packet. Upstream restarts from a header.
- Transfer rules:
  - Input beat transfers when in_valid[c] && in_ready[c].
  - Output beat transfers when out_valid && out_ready.
  - in_ready[c] = (c==grant) && (state!=IDLE) && (!out_valid || out_ready). Combinational; at most one bit set.
- Output register:
  - An accepted input beat appears on out_data/out_valid the next cycle. Latency is 1.
  - out_valid stays high, and out_data/out_ch/out_last stay stable, until out_ready.
  - Full throughput of 1 beat/cycle within a packet while out_ready=1.
- FSM state IDLE:
  - If any in_valid: grant = first c with in_valid[c], searching rr_ptr, rr_ptr+1, ... mod NUM_CH. Register grant and go to HEADER.
  - Otherwise stay in IDLE.
  - Cost: one bubble cycle per packet.
- FSM state HEADER, on header transfer:
  - L = header[LEN_WIDTH-1:0].
  - If L > MAX_LEN: remaining = MAX_LEN and set len_err. Otherwise remaining = L.
  - If L==0: header beat carries out_last=1, rr_ptr = (grant+1) mod NUM_CH, go to IDLE.
  - Else go to PAYLOAD.
- FSM state PAYLOAD, on each transfer:
  - remaining decrements.
  - When the beat that brings remaining from 1 to 0 is accepted: that beat gets out_last=1, rr_ptr = (grant+1) mod NUM_CH, go to IDLE.
  - If L was clamped, the beats beyond MAX_LEN belong to the next packet on that channel. Upstream is in error; no recovery is attempted.
- Arbitration is held: in_valid dropping mid-packet stalls the packet; the grant is not released. Other channels wait.
- rr_ptr advances only at packet end, so no channel starves while others are continuously valid.
- out_ch = grant, registered alongside out_data.
- Width rules: remaining is LEN_WIDTH bits; the compare against MAX_LEN is unsigned. MAX_LEN must be < 2**LEN_WIDTH.
- len_err clears only on reset.

Optional Feature:
- Macro: RR_AGG_CH_TAG_EN.
- Defined: on the output header beat, bits [DATA_WIDTH-1 -: CH_W] are overwritten with grant. Payload beats are untouched.
- Not defined: header beats pass through unmodified. out_ch is present in both builds.

Test Plan:
- NUM_CH=4; ch2 only, header L=3, out_ready=1 -> 4 output beats on consecutive cycles, first one 1 cycle after the header transfer. out_ch=2 throughout; out_last only on beat 4; rr_ptr=3 afterwards.
- All 4 channels continuously valid, every packet L=1 -> grant order 0,1,2,3,0. Each packet is 2 beats plus a 1-cycle IDLE bubble; no channel gets two packets in a row.
- ch1 sends L=2; out_ready held 0 for 5 cycles after the first output beat -> out_valid=1 and out_data stable for those cycles; in_ready[1]=0 while the output register is full; no beat lost or duplicated.
- Header L=0 on ch3 -> single output beat with out_last=1; FSM returns to IDLE the next cycle.
- Header L=200 with MAX_LEN=64 -> exactly 65 beats forwarded, out_last on beat 65; len_err=1 and it stays set.
- reset driven 0 for 1 cycle during PAYLOAD of a ch0 packet -> next cycle out_valid=0, in_ready=0, len_err=0; ch0 wins the next arbitration. With RR_AGG_CH_TAG_EN, top CH_W header bits equal the channel index.
